// File: rtl/ac97_frame_tx_if.sv
// rtl/ac97_frame_tx_if.sv - AC'97 transmitter link: sample/command inputs and serial frame outputs
interface ac97_frame_tx_if #(
   parameter int SAMPLE_WIDTH = 20
);
   logic                    codec_ready;
   logic                    pcm_en;
   logic [SAMPLE_WIDTH-1:0] left_sample;
   logic [SAMPLE_WIDTH-1:0] right_sample;
   logic                    cmd_valid;
   logic                    cmd_rw;
   logic [6:0]              cmd_addr;
   logic [15:0]             cmd_data;
   logic                    cmd_ready;
   logic                    sync;
   logic                    sdata_out;
   logic                    strobe;

   modport master (
      output codec_ready, pcm_en, left_sample, right_sample,
      output cmd_valid, cmd_rw, cmd_addr, cmd_data,
      input  cmd_ready, sync, sdata_out, strobe
   );

   modport slave (
      input  codec_ready, pcm_en, left_sample, right_sample,
      input  cmd_valid, cmd_rw, cmd_addr, cmd_data,
      output cmd_ready, sync, sdata_out, strobe
   );
endinterface

// File: rtl/ac97_frame_tx.sv
// rtl/ac97_frame_tx.sv - AC'97 SDATA_OUT/SYNC frame generator with PCM slots 3/4 and register command slots 1/2
module ac97_frame_tx #(
   parameter int SAMPLE_WIDTH = 20
) (
   input  logic           clk,
   input  logic           rst,
   ac97_frame_tx_if.slave link
);
   logic [7:0]   pos;
   logic [7:0]   pos_next;
   logic         load;
   logic [255:0] shadow;
   logic [255:0] image;
   logic         sync_q;
   logic         sdata_q;
   logic         strobe_q;

   logic         cmd_taken;
   logic         pcm_ok;
   logic [15:0]  tag;
   logic [19:0]  slot1;
   logic [19:0]  slot2;
   logic [19:0]  slot3;
   logic [19:0]  slot4;

   logic [SAMPLE_WIDTH+19:0] left_ext;
   logic [SAMPLE_WIDTH+19:0] right_ext;

   assign pos_next = pos + 8'd1;
   assign load     = (pos == 8'd255);

   assign link.cmd_ready = load & link.codec_ready & ~rst;
   assign cmd_taken      = link.cmd_valid & link.cmd_ready;
   assign pcm_ok         = link.codec_ready & link.pcm_en;

   // Top 20 bits of {sample, zeros} left-align the sample and zero-pad the slot LSBs.
   assign left_ext  = {link.left_sample, 20'b0};
   assign right_ext = {link.right_sample, 20'b0};

   assign tag   = {link.codec_ready, cmd_taken, cmd_taken & ~link.cmd_rw, pcm_ok, pcm_ok, 11'b0};
   assign slot1 = cmd_taken ? {link.cmd_rw, link.cmd_addr, 12'b0} : 20'b0;
   assign slot2 = (cmd_taken & ~link.cmd_rw) ? {link.cmd_data, 4'b0} : 20'b0;
   assign slot3 = pcm_ok ? left_ext[SAMPLE_WIDTH+19 -: 20] : 20'b0;
   assign slot4 = pcm_ok ? right_ext[SAMPLE_WIDTH+19 -: 20] : 20'b0;

   // Frame bit 0 sits at the MSB so the image shifts out left.
   assign image = {tag, slot1, slot2, slot3, slot4, 160'b0};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos      <= 8'd255;
         shadow   <= '0;
         sync_q   <= 1'b0;
         sdata_q  <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         pos      <= pos_next;
         sync_q   <= (pos_next <= 8'd15);
         strobe_q <= (pos_next == 8'd0);
         if (load) begin
            sdata_q <= image[255];
            shadow  <= {image[254:0], 1'b0};
         end else begin
            sdata_q <= shadow[255];
            shadow  <= {shadow[254:0], 1'b0};
         end
      end
   end

   assign link.sync      = sync_q;
   assign link.sdata_out = sdata_q;
   assign link.strobe    = strobe_q;
endmodule

// File: tb/tb_ac97_frame_tx.sv
// tb/tb_ac97_frame_tx.sv - self-checking bench for ac97_frame_tx against a frame-level model
module tb_ac97_frame_tx;
   localparam int SW = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   change_at = -1;
   int   drop_at   = -1;
   logic [255:0] last_obs;

   always #5 clk = ~clk;

   ac97_frame_tx_if #(.SAMPLE_WIDTH(SW)) link ();

   ac97_frame_tx #(.SAMPLE_WIDTH(SW)) dut (
      .clk  (clk),
      .rst  (rst),
      .link (link.slave)
   );

   task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   // Place a field MSB-first at frame bit positions start..start+width-1.
   function automatic logic [255:0] put(input logic [255:0] f, input int start, input int width,
                                        input logic [31:0] val);
      for (int i = 0; i < width; i++) f[start+i] = val[width-1-i];
      return f;
   endfunction

   function automatic logic [31:0] get(input logic [255:0] f, input int start, input int width);
      logic [31:0] v = 0;
      for (int i = 0; i < width; i++) v = (v << 1) | 32'(f[start+i]);
      return v;
   endfunction

   function automatic logic [255:0] model_frame(input bit ready, input bit pcm, input bit taken,
      input bit rw, input logic [6:0] addr, input logic [15:0] data,
      input logic [SW-1:0] l, input logic [SW-1:0] r);
      logic [255:0] f = '0;
      logic [31:0]  t;
      if (!ready) return f;
      t = 32'h8000;
      if (taken) t += 32'h4000;
      if (taken && !rw) t += 32'h2000;
      if (pcm) t += 32'h1800;
      f = put(f, 0, 16, t);
      if (taken) f = put(f, 16, 20, (32'(rw) << 19) + (32'(addr) << 12));
      if (taken && !rw) f = put(f, 36, 20, 32'(data) << 4);
      if (pcm) begin
         f = put(f, 56, 20, 32'(l) << (20 - SW));
         f = put(f, 76, 20, 32'(r) << (20 - SW));
      end
      return f;
   endfunction

   // Entered at the falling edge of the cycle before a LOAD edge; returns at the same point one frame later.
   task automatic run_frame(input string name);
      logic [255:0] exp_data, exp_sync, exp_strobe, exp_ready;
      logic [255:0] obs_data, obs_sync, obs_strobe, obs_ready;
      bit taken;
      taken    = link.cmd_valid && link.codec_ready;
      exp_data = model_frame(link.codec_ready, link.pcm_en, taken, link.cmd_rw, link.cmd_addr,
                             link.cmd_data, link.left_sample, link.right_sample);
      exp_sync = '0; exp_strobe = '0; exp_ready = '0;
      for (int k = 0; k < 16; k++) exp_sync[k] = 1'b1;
      exp_strobe[0] = 1'b1;
      for (int k = 0; k < 256; k++) begin
         @(posedge clk);
         @(negedge clk);
         obs_data[k]   = link.sdata_out;
         obs_sync[k]   = link.sync;
         obs_strobe[k] = link.strobe;
         obs_ready[k]  = link.cmd_ready;
         if (k == 255) exp_ready[255] = link.codec_ready;
         if (k == change_at) begin
            link.left_sample  = SW'($urandom);
            link.right_sample = SW'($urandom);
            link.pcm_en       = ~link.pcm_en;
         end
         if (k == drop_at) link.cmd_valid = 1'b0;
      end
      check({name, ".data"}, obs_data, exp_data);
      check({name, ".sync"}, obs_sync, exp_sync);
      check({name, ".strobe"}, obs_strobe, exp_strobe);
      check({name, ".ready"}, obs_ready, exp_ready);
      last_obs = obs_data;
   endtask

   task automatic advance(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, 256'({link.sync, link.sdata_out, link.strobe, link.cmd_ready}), 256'(0));
   endtask

   initial begin
      link.codec_ready  = 1'b1;
      link.pcm_en       = 1'b0;
      link.left_sample  = '0;
      link.right_sample = '0;
      link.cmd_valid    = 1'b0;
      link.cmd_rw       = 1'b0;
      link.cmd_addr     = '0;
      link.cmd_data     = '0;

      // reset state, then first LOAD edge right after release
      advance(3);
      check_reset_outputs("reset_hold");
      rst = 1'b0;
      #1;
      check("ready_after_release", 256'(link.cmd_ready), 256'(1));
      run_frame("idle0");
      check("idle_tag", 256'(get(last_obs, 0, 16)), 256'(16'h8000));
      run_frame("idle1");

      // PCM with mid-frame input changes
      link.pcm_en = 1'b1;
      link.left_sample  = 20'h12345;
      link.right_sample = 20'hFEDCB;
      change_at = 40;
      run_frame("pcm");
      change_at = -1;
      check("pcm_tag", 256'(get(last_obs, 0, 16)), 256'(16'h9800));
      check("pcm_left", 256'(get(last_obs, 56, 20)), 256'(20'h12345));
      check("pcm_right", 256'(get(last_obs, 76, 20)), 256'(20'hFEDCB));

      // register write, valid dropped mid-frame
      link.pcm_en = 1'b0;
      link.cmd_valid = 1'b1; link.cmd_rw = 1'b0; link.cmd_addr = 7'h02; link.cmd_data = 16'h0808;
      drop_at = 10;
      run_frame("cmd_wr");
      check("wr_tag", 256'(get(last_obs, 0, 16)), 256'(16'hE000));
      check("wr_slot1", 256'(get(last_obs, 16, 20)), 256'(20'h02000));
      check("wr_slot2", 256'(get(last_obs, 36, 20)), 256'(20'h08080));
      run_frame("after_wr");
      check("after_wr_slots", 256'(get(last_obs, 16, 40)), 256'(0));

      // register read
      link.cmd_valid = 1'b1; link.cmd_rw = 1'b1; link.cmd_addr = 7'h26; link.cmd_data = 16'hFFFF;
      run_frame("cmd_rd");
      check("rd_tag", 256'(get(last_obs, 0, 16)), 256'(16'hC000));
      check("rd_slot1", 256'(get(last_obs, 16, 20)), 256'(20'hA6000));
      check("rd_slot2", 256'(get(last_obs, 36, 20)), 256'(0));

      // codec not ready: nothing taken, strobe/sync still run
      link.codec_ready = 1'b0; link.cmd_valid = 1'b1; link.pcm_en = 1'b1;
      drop_at = -1;
      run_frame("not_ready0");
      run_frame("not_ready1");
      check("not_ready_frame", last_obs, 256'(0));
      link.codec_ready = 1'b1;
      link.cmd_valid = 1'b0;
      run_frame("ready_again");

      // randomized frames
      for (int n = 0; n < 8; n++) begin
         link.codec_ready  = ($urandom_range(0, 3) != 0);
         link.pcm_en       = 1'($urandom);
         link.left_sample  = SW'($urandom);
         link.right_sample = SW'($urandom);
         link.cmd_valid    = 1'($urandom);
         link.cmd_rw       = 1'($urandom);
         link.cmd_addr     = 7'($urandom);
         link.cmd_data     = 16'($urandom);
         change_at = $urandom_range(0, 254);
         drop_at   = $urandom_range(0, 254);
         run_frame("random");
      end
      change_at = -1;
      drop_at   = -1;

      // reset asserted at pos 100, then again at pos 3 while SYNC and data are high
      link.codec_ready = 1'b1; link.pcm_en = 1'b1; link.cmd_valid = 1'b0;
      link.left_sample = 20'hABCDE; link.right_sample = 20'h13579;
      advance(101);
      rst = 1'b1;
      #1;
      check_reset_outputs("reset_pos100");
      @(negedge clk);
      rst = 1'b0;
      run_frame("post_reset100");
      advance(4);
      check("pre_reset_pos3", 256'({link.sync, link.sdata_out}), 256'(2'b11));
      rst = 1'b1;
      #1;
      check_reset_outputs("reset_pos3");
      advance(2);
      check_reset_outputs("reset_pos3_hold");
      rst = 1'b0;
      run_frame("post_reset3");
      check("post_reset3_left", 256'(get(last_obs, 56, 20)), 256'(20'hABCDE));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
